// File: rtl/led_spi_multi.sv
// Lockstep N-channel serial LED-chain driver: header word, then RAM-fetched pixel
// words per channel, then an idle-low latch gap; frame config snapshotted per frame.
module led_spi_multi #(
  parameter int CHANNELS   = 4,
  parameter int WORD_BITS  = 16,
  parameter int CHIP_WORDS = 3,
  parameter int CHIP_W     = 9,
  parameter int ADDR_W     = 12,
  parameter int DIV_W      = 8,
  parameter int LATCH_BITS = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [CHIP_W-1:0]             chipcount,
  input  logic [DIV_W-1:0]              clk_div,
  input  logic [CHANNELS-1:0]           ch_enable,
  input  logic [WORD_BITS-1:0]          header,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [CHANNELS*WORD_BITS-1:0] rd_data,
  output logic [CHANNELS-1:0]           spi_c,
  output logic [CHANNELS-1:0]           spi_d,
  output logic                          start_flag,
  output logic                          busy,
  output logic [15:0]                   frame_count
);

  localparam int BIT_MAX = (LATCH_BITS > WORD_BITS) ? LATCH_BITS : WORD_BITS;
  localparam int BIT_W   = $clog2(BIT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_LATCH} state_t;

  state_t                        r_state, w_state_next;
  logic                          w_frame_start;
  logic [CHIP_W-1:0]             r_chips;
  logic [DIV_W-1:0]              r_div_max;
  logic [CHANNELS-1:0]           r_ch_en;
  logic [DIV_W-1:0]              r_div_cnt;
  logic                          r_half;
  logic [BIT_W-1:0]              r_bit;
  logic [ADDR_W-1:0]             r_word_cnt;
  logic                          r_fetched;
  logic                          r_cap;
  logic                          r_start;
  logic [15:0]                   r_frames;
  logic [CHANNELS*WORD_BITS-1:0] r_shift;
  logic [CHANNELS*WORD_BITS-1:0] r_hold;
  logic [CHANNELS*WORD_BITS-1:0] w_next_word;
  logic [ADDR_W-1:0]             w_total;
  logic                          w_in_word, w_half_end, w_bit_end;
  logic                          w_word_end, w_latch_end, w_rd_en;

  assign w_in_word   = (r_state == S_HEADER) || (r_state == S_DATA);
  assign w_half_end  = (r_div_cnt == r_div_max);
  assign w_bit_end   = w_half_end && r_half;
  assign w_word_end  = w_in_word && w_bit_end && (r_bit == BIT_W'(WORD_BITS - 1));
  assign w_latch_end = (r_state == S_LATCH) && w_bit_end && (r_bit == BIT_W'(LATCH_BITS - 1));
  assign w_total     = ADDR_W'(r_chips) * ADDR_W'(CHIP_WORDS);
  assign w_rd_en     = w_in_word && !r_half && (r_div_cnt == '0) &&
                       (r_bit == BIT_W'(WORD_BITS - 1)) && (r_word_cnt < w_total);
  // With clk_div=0 the word boundary coincides with the capture clk, so bypass the holding register.
  assign w_next_word = r_cap ? rd_data : r_hold;

  assign rd_en       = w_rd_en;
  assign rd_addr     = r_word_cnt;
  assign start_flag  = r_start;
  assign busy        = (r_state != S_IDLE);
  assign frame_count = r_frames;

  always_comb begin
    spi_c = '0;
    spi_d = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      spi_c[c] = w_in_word && r_half && r_ch_en[c];
      spi_d[c] = w_in_word && r_ch_en[c] && r_shift[c*WORD_BITS + WORD_BITS - 1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_next  = S_HEADER;
          w_frame_start = 1'b1;
        end
      end
      S_HEADER, S_DATA: begin
        if (w_word_end) w_state_next = r_fetched ? S_DATA : S_LATCH;
      end
      S_LATCH: begin
        if (w_latch_end) begin
          if (enable) begin
            w_state_next  = S_HEADER;
            w_frame_start = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chips    <= '0;
      r_div_max  <= '0;
      r_ch_en    <= '0;
      r_div_cnt  <= '0;
      r_half     <= 1'b0;
      r_bit      <= '0;
      r_word_cnt <= '0;
      r_fetched  <= 1'b0;
      r_cap      <= 1'b0;
      r_start    <= 1'b0;
      r_frames   <= '0;
      r_shift    <= '0;
      r_hold     <= '0;
    end else begin
      r_start <= w_frame_start;
      r_cap   <= w_rd_en;
      if (r_cap) r_hold <= rd_data;
      if (w_frame_start) begin
        r_chips    <= chipcount;
        r_div_max  <= clk_div;
        r_ch_en    <= ch_enable;
        r_shift    <= {CHANNELS{header}};
        r_div_cnt  <= '0;
        r_half     <= 1'b0;
        r_bit      <= '0;
        r_word_cnt <= '0;
        r_fetched  <= 1'b0;
      end else if (r_state != S_IDLE) begin
        r_div_cnt <= w_half_end ? '0 : r_div_cnt + 1'b1;
        if (w_half_end) r_half <= ~r_half;
        if (w_bit_end) begin
          r_bit <= (w_word_end || w_latch_end) ? '0 : r_bit + 1'b1;
          for (int unsigned c = 0; c < CHANNELS; c++)
            r_shift[c*WORD_BITS +: WORD_BITS] <= {r_shift[c*WORD_BITS +: WORD_BITS-1], 1'b0};
        end
        if (w_rd_en) begin
          r_word_cnt <= r_word_cnt + 1'b1;
          r_fetched  <= 1'b1;
        end
        if (w_word_end) begin
          r_fetched <= 1'b0;
          if (r_fetched) r_shift <= w_next_word;
        end
      end
      if (w_latch_end) r_frames <= r_frames + 1'b1;
    end
  end

endmodule

// File: tb/tb_led_spi_multi.sv
// Randomised frame bench for led_spi_multi: stimulus pushes per-frame expectations,
// a negedge monitor deserialises the outputs and checks them against those.
module tb_led_spi_multi;
  localparam int CH = 4;
  localparam int WB = 16;
  localparam int CW = 3;
  localparam int LB = 24;

  logic          clk = 1'b0;
  logic          rst, enable;
  logic [8:0]    chipcount;
  logic [7:0]    clk_div;
  logic [CH-1:0] ch_enable;
  logic [15:0]   header;
  logic          rd_en;
  logic [11:0]   rd_addr;
  logic [63:0]   rd_data;
  logic [CH-1:0] spi_c, spi_d;
  logic          start_flag, busy;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  led_spi_multi #(.CHANNELS(CH), .WORD_BITS(WB), .CHIP_WORDS(CW), .CHIP_W(9),
                  .ADDR_W(12), .DIV_W(8), .LATCH_BITS(LB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .chipcount(chipcount), .clk_div(clk_div),
    .ch_enable(ch_enable), .header(header), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .spi_c(spi_c), .spi_d(spi_d), .start_flag(start_flag),
    .busy(busy), .frame_count(frame_count));

  typedef struct {
    logic [15:0] hdr;
    int unsigned chips;
    int unsigned div;
    logic [3:0]  chen;
  } cfg_t;

  logic [63:0] ram [16];
  cfg_t        f_q [$];
  logic [15:0] exp_q [CH][$];
  int unsigned n_vec = 0, n_err = 0, cyc = 0;

  // 1-cycle-latency RAM; garbage on non-read cycles exposes stale captures
  always @(posedge clk) begin
    if (rd_en && rd_addr < 12'd16) rd_data <= ram[rd_addr[3:0]];
    else                           rd_data <= {$urandom, $urandom};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned flen(input cfg_t f);
    return 2 * (f.div + 1) * (WB * (1 + f.chips * CW) + LB);
  endfunction

  // ---------------- monitor ----------------
  cfg_t        fe;
  logic        in_frame = 1'b0, bad_d, bad_fc, bad_busy;
  logic [3:0]  active, pc = '0, pd = '0;
  logic [15:0] exp_fc = '0;
  int unsigned st_clk, rd_cnt, hi_min, hi_max;
  int unsigned run_len [CH], rx_bits [CH], rx_cnt [CH];
  logic [15:0] rx_sh [CH];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      f_q.delete();
      for (int c = 0; c < CH; c++) begin
        exp_q[c].delete(); run_len[c] = 0; rx_bits[c] = 0; rx_cnt[c] = 0;
      end
      exp_fc = '0; in_frame = 1'b0; pc = '0; pd = '0;
    end else begin
      if (in_frame && f_q.size() > 0 && cyc == st_clk + flen(f_q[0])) begin
        fe = f_q.pop_front();
        exp_fc++;
        chk("frame_count", frame_count, exp_fc);
        chk("restart_start", start_flag, enable);
        chk("busy_at_end", busy, enable);
        chk("rd_count", rd_cnt, fe.chips * CW);
        chk("active_ch", active, fe.chen);
        chk("mid_frame_flags", {bad_d, bad_fc, bad_busy}, 0);
        if (fe.chen != 0) begin
          chk("hi_min", hi_min, fe.div + 1);
          chk("hi_max", hi_max, fe.div + 1);
        end
        for (int c = 0; c < CH; c++)
          chk($sformatf("words_ch%0d", c), rx_cnt[c], fe.chen[c] ? 1 + fe.chips * CW : 0);
        in_frame = 1'b0;
      end
      if (start_flag && in_frame) chk("spurious_start", start_flag, 0);
      else if (start_flag) begin
        in_frame = 1'b1; st_clk = cyc; rd_cnt = 0; hi_min = 1000; hi_max = 0;
        active = '0; bad_d = 1'b0; bad_fc = 1'b0; bad_busy = 1'b0;
        for (int c = 0; c < CH; c++) begin
          run_len[c] = 0; rx_bits[c] = 0; rx_cnt[c] = 0;
        end
      end
      if (in_frame) begin
        active   |= spi_c | spi_d;
        bad_busy |= !busy;
        bad_fc   |= (frame_count != exp_fc);
        for (int c = 0; c < CH; c++) begin
          if (spi_d[c] != pd[c] && !(pc[c] && !spi_c[c]) && !start_flag) bad_d = 1'b1;
          if (spi_c[c]) run_len[c]++;
          else if (pc[c]) begin
            if (run_len[c] < hi_min) hi_min = run_len[c];
            if (run_len[c] > hi_max) hi_max = run_len[c];
            run_len[c] = 0;
          end
          if (spi_c[c] && !pc[c]) begin
            rx_sh[c] = {rx_sh[c][14:0], spi_d[c]};
            rx_bits[c]++;
            if (rx_bits[c] == WB) begin
              rx_bits[c] = 0;
              rx_cnt[c]++;
              if (exp_q[c].size() > 0)
                chk($sformatf("word_ch%0d", c), rx_sh[c], exp_q[c].pop_front());
            end
          end
        end
        if (rd_en) begin
          if (f_q.size() > 0) begin
            chk("rd_addr", rd_addr, rd_cnt);
            chk("rd_offset", cyc - st_clk, (rd_cnt * WB + WB - 1) * 2 * (f_q[0].div + 1));
          end
          rd_cnt++;
        end
      end else if (rd_en) chk("rd_en_idle", rd_en, 0);
      pc = spi_c;
      pd = spi_d;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input cfg_t f);
    header = f.hdr; chipcount = 9'(f.chips); clk_div = 8'(f.div); ch_enable = f.chen;
  endtask

  task automatic push_exp(input cfg_t f);
    f_q.push_back(f);
    for (int c = 0; c < CH; c++) begin
      if (f.chen[c]) begin
        exp_q[c].push_back(f.hdr);
        for (int k = 0; k < int'(f.chips) * CW; k++) exp_q[c].push_back(ram[k][c*WB +: WB]);
      end
    end
  endtask

  task automatic wait_start();
    int unsigned n = 0;
    do begin tick(); n++; end while (!start_flag && n < 5000);
    if (!start_flag) chk("start_timeout", start_flag, 1);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin tick(); n++; end while (busy && n < 5000);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic issue(input cfg_t f);
    drive(f); enable = 1'b1; wait_start(); push_exp(f);
  endtask

  function automatic cfg_t mk(input logic [15:0] h, input int unsigned ch,
                              input int unsigned dv, input logic [3:0] en);
    cfg_t f;
    f.hdr = h; f.chips = ch; f.div = dv; f.chen = en;
    return f;
  endfunction

  function automatic cfg_t rnd();
    return mk(16'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 4'($urandom));
  endfunction

  cfg_t cur;

  initial begin
    rst = 1'b1; enable = 1'b0; drive(mk(16'h0, 0, 0, 4'h0));
    for (int k = 0; k < 16; k++) begin
      logic [15:0] w;
      w = 16'h1000 + 16'(k);
      ram[k] = {w, w, w, w};
    end
    repeat (3) tick();
    chk("rst_spi_c", spi_c, 0);      chk("rst_spi_d", spi_d, 0);
    chk("rst_rd_en", rd_en, 0);      chk("rst_rd_addr", rd_addr, 0);
    chk("rst_start", start_flag, 0); chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    rst = 1'b0;
    tick();

    issue(mk(16'hA5C3, 2, 0, 4'hF));
    cur = mk(16'($urandom), 1, 3, 4'h5);
    drive(cur); wait_start(); push_exp(cur);
    drive(mk(16'h8001, 0, 0, 4'hF));   // ch_enable=1111 mid-frame, must not apply yet
    enable = 1'b0;
    wait_idle();
    repeat (20) tick();
    chk("stays_idle", busy, 0);
    issue(mk(16'h8001, 0, 0, 4'hF));
    cur = mk(16'($urandom), 3, 1, 4'hF);
    drive(cur); wait_start(); push_exp(cur);
    begin
      int unsigned n = 0;
      do begin tick(); n++; end while (!rd_en && n < 2000);
      if (!rd_en) chk("rd_timeout", rd_en, 1);
    end
    enable = 1'b0;
    wait_idle();
    repeat (20) tick();
    chk("stays_idle_after_drop", busy, 0);

    for (int k = 0; k < 16; k++) ram[k] = {$urandom, $urandom};
    issue(rnd());
    for (int i = 0; i < 10; i++) begin
      cur = rnd();
      drive(cur);
      if ($urandom_range(0, 1) == 1) begin
        enable = 1'b0;
        wait_idle();
        repeat ($urandom_range(0, 4)) tick();
        enable = 1'b1;
      end
      wait_start(); push_exp(cur);
    end
    enable = 1'b0;
    wait_idle();

    issue(mk(16'($urandom), 2, 1, 4'hF));
    repeat (60) tick();
    enable = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_spi_c", spi_c, 0);      chk("mrst_spi_d", spi_d, 0);
    chk("mrst_rd_en", rd_en, 0);      chk("mrst_start", start_flag, 0);
    chk("mrst_busy", busy, 0);        chk("mrst_fc", frame_count, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    issue(rnd());
    enable = 1'b0;
    wait_idle();
    repeat (5) tick();
    chk("final_fc", frame_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
